// File: rtl/adc_cap_avg_filter.sv
// Two-channel decimating moving-average filter for the capacitor-voltage ADC path.
// One sample every SAMPLE_DIV cycles, 2^AVG_LOG2-point running average per channel.
module adc_cap_avg_filter #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned AVG_LOG2   = 4,
  parameter int unsigned SAMPLE_DIV = 50
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              filter_clr,
  input  logic [DATA_W-1:0] filter_data_in1,
  input  logic [DATA_W-1:0] filter_data_in2,
  output logic [DATA_W-1:0] filtered_data_out1,
  output logic [DATA_W-1:0] filtered_data_out2,
  output logic              filter_valid,
  output logic              filter_ready
);

  localparam int unsigned N      = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned FILL_W = AVG_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_OUTPUT
  } pipe_state_t;

  pipe_state_t state, state_next;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic                do_update;
  logic                do_output;

  logic [DATA_W-1:0]   sample1, sample2;
  logic [DATA_W-1:0]   oldest1, oldest2;
  logic [DATA_W-1:0]   hist1 [N];
  logic [DATA_W-1:0]   hist2 [N];
  logic [SUM_W-1:0]    sum1, sum2;
  logic [AVG_LOG2-1:0] ptr;
  logic [FILL_W-1:0]   fill;

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
    end else if (filter_clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Ticks are at least four cycles apart, so the pipeline is always idle when one arrives.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_update  = 1'b0;
    do_output  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tick) state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        do_update  = 1'b1;
        state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        do_output  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (filter_clr) begin
      state_next = ST_IDLE;
      do_update  = 1'b0;
      do_output  = 1'b0;
    end
  end

  // Stage 0: capture inputs and the entry about to be overwritten.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sample1 <= '0;
      sample2 <= '0;
      oldest1 <= '0;
      oldest2 <= '0;
    end else if (filter_clr) begin
      sample1 <= '0;
      sample2 <= '0;
      oldest1 <= '0;
      oldest2 <= '0;
    end else if (tick) begin
      sample1 <= filter_data_in1;
      sample2 <= filter_data_in2;
      oldest1 <= hist1[ptr];
      oldest2 <= hist2[ptr];
    end
  end

  // Stage 1: running sums, history write, pointer and fill count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        hist1[i] <= '0;
        hist2[i] <= '0;
      end
      sum1 <= '0;
      sum2 <= '0;
      ptr  <= '0;
      fill <= '0;
    end else if (filter_clr) begin
      for (int unsigned i = 0; i < N; i++) begin
        hist1[i] <= '0;
        hist2[i] <= '0;
      end
      sum1 <= '0;
      sum2 <= '0;
      ptr  <= '0;
      fill <= '0;
    end else if (do_update) begin
      sum1       <= sum1 + SUM_W'(sample1) - SUM_W'(oldest1);
      sum2       <= sum2 + SUM_W'(sample2) - SUM_W'(oldest2);
      hist1[ptr] <= sample1;
      hist2[ptr] <= sample2;
      ptr        <= ptr + 1'b1;
      if (fill != FILL_W'(N)) fill <= fill + 1'b1;
    end
  end

  // Stage 2: divide by N by dropping the low AVG_LOG2 bits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      filtered_data_out1 <= '0;
      filtered_data_out2 <= '0;
      filter_valid       <= 1'b0;
      filter_ready       <= 1'b0;
    end else if (filter_clr) begin
      filtered_data_out1 <= '0;
      filtered_data_out2 <= '0;
      filter_valid       <= 1'b0;
      filter_ready       <= 1'b0;
    end else begin
      filter_valid <= do_output;
      if (do_output) begin
        filtered_data_out1 <= sum1[SUM_W-1:AVG_LOG2];
        filtered_data_out2 <= sum2[SUM_W-1:AVG_LOG2];
        if (fill == FILL_W'(N)) filter_ready <= 1'b1;
      end
    end
  end

endmodule
